// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer (IDLE/DECODE/EXEC/MEM/WB).
// Execute controls are decoded on the accept edge so they are valid from DECODE
// through WB. The retire and stall counters exist only when the
// EXEC_SEQ_PERFCNT_EN macro is defined.
module exec_sequencer #(
  parameter int DBITS        = 32,
  parameter int OP_BIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    inst_valid,
  output logic                    inst_ready,
  input  logic [31:0]             inst,
  input  logic                    cond_in,
  input  logic                    mem_ack,
  output logic                    useZero,
  output logic                    useImm,
  output logic                    isMvhi,
  output logic                    isBranchOrCond,
  output logic [OP_BIT_WIDTH-1:0] opAlu,
  output logic [OP_BIT_WIDTH-1:0] opCond,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    reg_we,
  output logic                    pc_redirect,
  output logic                    retire,
  output logic                    illegal
`ifdef EXEC_SEQ_PERFCNT_EN
  ,
  output logic [DBITS-1:0]        retire_count,
  output logic [DBITS-1:0]        stall_count
`endif
);

  localparam int OPW = OP_BIT_WIDTH;

  localparam logic [OPW-1:0] OP_ALUR  = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_ALUI  = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_CMPR  = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_CMPI  = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_BCOND = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_SW    = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_LW    = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(4'b1011);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op1_q, op1_d;
  logic           inst_ready_q, inst_ready_d;
  logic           use_zero_q, use_zero_d;
  logic           use_imm_q, use_imm_d;
  logic           is_mvhi_q, is_mvhi_d;
  logic           is_boc_q, is_boc_d;
  logic [OPW-1:0] op_alu_q, op_alu_d;
  logic [OPW-1:0] op_cond_q, op_cond_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic           reg_we_q, reg_we_d;
  logic           pc_redirect_q, pc_redirect_d;
  logic           retire_q, retire_d;
  logic           illegal_q, illegal_d;

  logic [OPW-1:0] op1_in, op2_in;
  logic           is_branch, is_sw, is_mvhi_in, is_boc_in;
  logic           unused_inst_bits;

  assign op1_in = inst[31 -: OPW];
  assign op2_in = inst[31-OPW -: OPW];
  assign unused_inst_bits = ^inst[31-2*OPW:0];

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op == OP_ALUR) || (op == OP_ALUI) || (op == OP_CMPR) || (op == OP_CMPI) ||
           (op == OP_BCOND) || (op == OP_SW) || (op == OP_LW) || (op == OP_JAL);
  endfunction

  function automatic logic op_writes_reg(input logic [OPW-1:0] op);
    return (op == OP_ALUR) || (op == OP_ALUI) || (op == OP_CMPR) || (op == OP_CMPI) ||
           (op == OP_LW) || (op == OP_JAL);
  endfunction

  // Execute-control decode of the offered instruction word.
  always_comb begin
    is_branch  = op1_in[2] & ~op1_in[0];
    is_sw      = op1_in[2] &  op1_in[0];
    is_mvhi_in = op1_in[3] & ~op1_in[1] & op2_in[1] & op2_in[0];
    is_boc_in  = op1_in[1] & ~op1_in[0];
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    op1_d         = op1_q;
    inst_ready_d  = 1'b0;
    use_zero_d    = use_zero_q;
    use_imm_d     = use_imm_q;
    is_mvhi_d     = is_mvhi_q;
    is_boc_d      = is_boc_q;
    op_alu_d      = op_alu_q;
    op_cond_d     = op_cond_q;
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    reg_we_d      = 1'b0;
    pc_redirect_d = 1'b0;
    retire_d      = 1'b0;
    illegal_d     = 1'b0;
    case (state_q)
      IDLE: begin
        inst_ready_d = 1'b1;
        if (inst_valid && inst_ready_q) begin
          state_d      = DECODE;
          inst_ready_d = 1'b0;
          op1_d        = op1_in;
          use_zero_d   = (is_branch & op2_in[2]) | is_mvhi_in;
          use_imm_d    = op1_in[3] | is_sw;
          is_mvhi_d    = is_mvhi_in;
          is_boc_d     = is_boc_in;
          op_alu_d     = is_boc_in ? OPW'(1) : op2_in;
          op_cond_d    = op2_in;
          illegal_d    = ~op_legal(op1_in);
        end
      end
      DECODE: begin
        if (op_legal(op1_q)) begin
          state_d = EXEC;
        end else begin
          state_d      = IDLE;
          inst_ready_d = 1'b1;
        end
      end
      EXEC: begin
        if ((op1_q == OP_LW) || (op1_q == OP_SW)) begin
          state_d   = MEM;
          mem_req_d = 1'b1;
          mem_we_d  = (op1_q == OP_SW);
        end else begin
          state_d       = WB;
          retire_d      = 1'b1;
          reg_we_d      = op_writes_reg(op1_q);
          pc_redirect_d = (op1_q == OP_JAL) | ((op1_q == OP_BCOND) & cond_in);
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_d  = WB;
          retire_d = 1'b1;
          reg_we_d = op_writes_reg(op1_q);
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end
      WB: begin
        state_d      = IDLE;
        inst_ready_d = 1'b1;
      end
      default: begin
        state_d      = IDLE;
        inst_ready_d = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered outputs, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op1_q         <= '0;
      inst_ready_q  <= 1'b1;
      use_zero_q    <= 1'b0;
      use_imm_q     <= 1'b0;
      is_mvhi_q     <= 1'b0;
      is_boc_q      <= 1'b0;
      op_alu_q      <= '0;
      op_cond_q     <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      reg_we_q      <= 1'b0;
      pc_redirect_q <= 1'b0;
      retire_q      <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op1_q         <= op1_d;
      inst_ready_q  <= inst_ready_d;
      use_zero_q    <= use_zero_d;
      use_imm_q     <= use_imm_d;
      is_mvhi_q     <= is_mvhi_d;
      is_boc_q      <= is_boc_d;
      op_alu_q      <= op_alu_d;
      op_cond_q     <= op_cond_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      reg_we_q      <= reg_we_d;
      pc_redirect_q <= pc_redirect_d;
      retire_q      <= retire_d;
      illegal_q     <= illegal_d;
    end
  end

  // inst_ready is held low for as long as reset_n is asserted.
  assign inst_ready     = inst_ready_q & reset_n;
  assign useZero        = use_zero_q;
  assign useImm         = use_imm_q;
  assign isMvhi         = is_mvhi_q;
  assign isBranchOrCond = is_boc_q;
  assign opAlu          = op_alu_q;
  assign opCond         = op_cond_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign reg_we         = reg_we_q;
  assign pc_redirect    = pc_redirect_q;
  assign retire         = retire_q;
  assign illegal        = illegal_q;

`ifdef EXEC_SEQ_PERFCNT_EN
  logic [DBITS-1:0] retire_count_q, retire_count_d;
  logic [DBITS-1:0] stall_count_q, stall_count_d;

  // Free-running wrap-around counters: retire pulses and unacknowledged MEM cycles.
  always_comb begin
    retire_count_d = retire_count_q + (retire_q ? DBITS'(1) : DBITS'(0));
    stall_count_d  = stall_count_q + (((state_q == MEM) && !mem_ack) ? DBITS'(1) : DBITS'(0));
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      retire_count_q <= retire_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign retire_count = retire_count_q;
  assign stall_count  = stall_count_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: expected per-instruction results are queued
// when an instruction is offered and checked when the DUT retires it.
module tb_exec_sequencer;

  logic        clk;
  logic        reset_n;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        cond_in;
  logic        mem_ack;
  logic        useZero, useImm, isMvhi, isBranchOrCond;
  logic [3:0]  opAlu, opCond;
  logic        mem_req, mem_we, reg_we, pc_redirect, retire, illegal;
`ifdef EXEC_SEQ_PERFCNT_EN
  logic [31:0] retire_count, stall_count;
`endif

  exec_sequencer #(.DBITS(32), .OP_BIT_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .cond_in(cond_in), .mem_ack(mem_ack),
    .useZero(useZero), .useImm(useImm), .isMvhi(isMvhi), .isBranchOrCond(isBranchOrCond),
    .opAlu(opAlu), .opCond(opCond), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
    .pc_redirect(pc_redirect), .retire(retire), .illegal(illegal)
`ifdef EXEC_SEQ_PERFCNT_EN
    , .retire_count(retire_count), .stall_count(stall_count)
`endif
  );

  typedef struct {
    int         lat;
    int         nmem;
    logic       we;
    logic       reg_we;
    logic       pc;
    logic       use_zero;
    logic       use_imm;
    logic       is_mvhi;
    logic       is_boc;
    logic [3:0] op_alu;
    logic [3:0] op_cond;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int lat, input int nmem, input logic we, input logic rw,
                              input logic pc, input logic uz, input logic ui, input logic mv,
                              input logic boc, input logic [3:0] alu, input logic [3:0] cnd);
    exp_t e;
    e.lat = lat; e.nmem = nmem; e.we = we; e.reg_we = rw; e.pc = pc;
    e.use_zero = uz; e.use_imm = ui; e.is_mvhi = mv; e.is_boc = boc;
    e.op_alu = alu; e.op_cond = cnd;
    return e;
  endfunction

  // Offer one instruction, then follow it to retire and compare against the queued result.
  // nack = MEM cycle on which mem_ack is raised; stray holds mem_ack high for non-memory ops.
  task automatic run_inst(input string name, input logic [31:0] word, input logic cond,
                          input int nack, input logic stray, input exp_t e);
    exp_t got;
    int   k;
    int   nm;
    logic we_seen;
    logic done;
    sb.push_back(e);
    @(negedge clk);
    inst       = word;
    inst_valid = 1'b1;
    cond_in    = cond;
    mem_ack    = stray;
    tick();
    inst_valid = 1'b0;
    inst       = $urandom;
    chk({name, "_ready_busy"}, inst_ready, 1'b0);
    k = 0; nm = 0; we_seen = 1'b0; done = 1'b0;
    while (!done && k < 40) begin
      if (mem_req) begin
        nm++;
        we_seen = we_seen | mem_we;
        mem_ack = (nm == nack);
      end else if (nack != 0) begin
        mem_ack = 1'b0;
      end
      if (retire) begin
        done = 1'b1;
      end else begin
        tick();
        k++;
      end
    end
    chk({name, "_retired"}, done, 1'b1);
    if (done) begin
      chk({name, "_sb_nonempty"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk({name, "_latency"}, k + 1, got.lat);
        chk({name, "_mem_cycles"}, nm, got.nmem);
        chk({name, "_mem_we"}, we_seen, got.we);
        chk({name, "_reg_we"}, reg_we, got.reg_we);
        chk({name, "_pc_redirect"}, pc_redirect, got.pc);
        chk({name, "_useZero"}, useZero, got.use_zero);
        chk({name, "_useImm"}, useImm, got.use_imm);
        chk({name, "_isMvhi"}, isMvhi, got.is_mvhi);
        chk({name, "_isBranchOrCond"}, isBranchOrCond, got.is_boc);
        chk({name, "_opAlu"}, opAlu, got.op_alu);
        chk({name, "_opCond"}, opCond, got.op_cond);
      end
      mem_ack = 1'b0;
      tick();
      chk({name, "_retire_once"}, retire, 1'b0);
      chk({name, "_ready_after"}, inst_ready, 1'b1);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
`ifdef EXEC_SEQ_PERFCNT_EN
    logic [31:0] stall_before;
`endif
    reset_n    = 1'b0;
    inst_valid = 1'b0;
    inst       = 32'h0;
    cond_in    = 1'b0;
    mem_ack    = 1'b0;
    #2;
    chk("rst_inst_ready", inst_ready, 1'b0);
    chk("rst_outputs", {useZero, useImm, isMvhi, isBranchOrCond, opAlu, opCond,
                        mem_req, mem_we, reg_we, pc_redirect, retire, illegal}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_inst_ready", inst_ready, 1'b1);

    // lat nmem we rw pc uz ui mv boc alu cond
    run_inst("alur_add", 32'h00123456, 1'b0, 0, 1'b0,
             mk(3, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000));
    run_inst("alur_stray_ack", 32'h05ABCDEF, 1'b0, 0, 1'b1,
             mk(3, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0101, 4'b0101));
    run_inst("bcond_taken", 32'h6F000000, 1'b1, 0, 1'b0,
             mk(3, 0, 0, 0, 1, 1, 0, 0, 1, 4'b0001, 4'b1111));
    run_inst("bcond_not", 32'h6F000000, 1'b0, 0, 1'b0,
             mk(3, 0, 0, 0, 0, 1, 0, 0, 1, 4'b0001, 4'b1111));
`ifdef EXEC_SEQ_PERFCNT_EN
    stall_before = stall_count;
`endif
    run_inst("lw", 32'h90000010, 1'b0, 4, 1'b0,
             mk(7, 4, 0, 1, 0, 0, 1, 0, 0, 4'b0000, 4'b0000));
`ifdef EXEC_SEQ_PERFCNT_EN
    chk("lw_stall_count", stall_count - stall_before, 3);
`endif
    run_inst("mvhi", 32'h8B00FFFF, 1'b0, 0, 1'b0,
             mk(3, 0, 0, 1, 0, 1, 1, 1, 0, 4'b1011, 4'b1011));
    run_inst("sw", 32'h50000004, 1'b0, 1, 1'b0,
             mk(4, 1, 1, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0000));
    run_inst("jal", 32'hB0000000, 1'b0, 0, 1'b0,
             mk(3, 0, 0, 1, 1, 0, 1, 0, 0, 4'b0000, 4'b0000));
    run_inst("cmpi", 32'hA3000000, 1'b1, 0, 1'b0,
             mk(3, 0, 0, 1, 0, 0, 1, 0, 1, 4'b0001, 4'b0011));

    // Illegal opcode: one-cycle illegal pulse, no retire, back to IDLE.
    @(negedge clk);
    inst       = 32'hF0000000;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("ill_pulse", illegal, 1'b1);
    chk("ill_no_retire_d", retire, 1'b0);
    tick();
    chk("ill_pulse_end", illegal, 1'b0);
    chk("ill_ready", inst_ready, 1'b1);
    chk("ill_no_retire", retire, 1'b0);

    // Reset in the middle of a store's MEM phase.
    @(negedge clk);
    inst       = 32'h50000000;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
    tick();
    chk("sw_mem_req", mem_req, 1'b1);
    chk("sw_mem_we", mem_we, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmem_req", mem_req, 1'b0);
    chk("rstmem_we", mem_we, 1'b0);
    chk("rstmem_ready", inst_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rstmem_ready_rel", inst_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstmem_no_retire", retire, 1'b0);
    end
    chk("rstmem_idle", inst_ready, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have parameter DBITS, default 32, meaning datapath width.
REQ-002 The block SHALL have parameter OP_BIT_WIDTH, default 4, meaning width of op1/op2 fields.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port inst_valid, input, 1, fetch offers an instruction.
REQ-006 The block SHALL have port inst_ready, output, 1, sequencer accepts an instruction.
REQ-007 The block SHALL have port inst, input, 32, instruction word; op1 = inst[31:28], op2 = inst[27:24].
REQ-008 The block SHALL have port cond_in, input, 1, Execute condition result.
REQ-009 The block SHALL have port mem_ack, input, 1, data memory completes the access.
REQ-010 The block SHALL have outputs useZero, useImm, isMvhi, isBranchOrCond (1 each), opAlu and opCond (OP_BIT_WIDTH each): Execute controls.
REQ-011 The block SHALL have outputs mem_req, mem_we, reg_we, pc_redirect, retire and illegal (1 each).

Function
REQ-012 States SHALL be IDLE, DECODE, EXEC, MEM and WB.
REQ-013 inst_ready SHALL be 1 only in IDLE; IDLE->DECODE on inst_valid & inst_ready, latching op1/op2.
REQ-014 In DECODE, opcodes ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, BCOND 0110, SW 0101, LW 1001 and JAL 1011 SHALL go to EXEC; any other op1 SHALL pulse illegal for 1 cycle and return to IDLE without retire.
REQ-015 Execute controls SHALL be registered from the latched opcode and held stable from DECODE through WB: isBranch = op1[2]&~op1[0]; isSW = op1[2]&op1[0]; isMvhi = op1[3]&~op1[1]&op2[1]&op2[0]; useZero = (isBranch&op2[2])|isMvhi; useImm = op1[3]|isSW; isBranchOrCond = op1[1]&~op1[0]; opAlu = isBranchOrCond ? 0001 : op2; opCond = op2.
REQ-016 EXEC SHALL last 1 cycle and sample cond_in at its final edge; LW/SW -> MEM; all others -> WB.
REQ-017 In MEM, mem_req SHALL be 1 (mem_we=1 for SW) until mem_ack is sampled high, then -> WB; the state SHALL be held indefinitely without mem_ack.
REQ-018 In WB, reg_we SHALL be 1 for ALUR, ALUI, CMPR, CMPI, LW and JAL; pc_redirect SHALL be 1 for JAL, or BCOND with sampled cond_in=1.
REQ-019 WB SHALL assert retire for exactly 1 cycle and go to IDLE.
REQ-020 Latency from accept edge to retire SHALL be 3 cycles for non-memory ops, 3+N for LW/SW where N = cycles until mem_ack (N>=1).
REQ-021 mem_ack outside MEM and inst_valid outside IDLE SHALL be ignored.

Reset
REQ-022 reset_n low SHALL asynchronously force IDLE and drive all outputs 0 except inst_ready=1 (if reset_n is low inst_ready=0 until release, then 1).
REQ-023 Reset during MEM SHALL drop mem_req immediately; the in-flight instruction SHALL not retire.

Configuration
REQ-024 With EXEC_SEQ_PERFCNT_EN defined, outputs retire_count and stall_count (DBITS each) SHALL count retire pulses and MEM cycles with mem_ack=0, wrapping at 2^DBITS-1 -> 0, reset to 0.
REQ-025 Without EXEC_SEQ_PERFCNT_EN, those ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-026 ALUR ADD (inst=0x00xxxxxx), inst_valid 1 cycle -> opAlu=0000, useImm=0, reg_we=1 and retire 3 cycles after accept.
REQ-027 BCOND GTZ (op1=0110, op2=1111), cond_in=1 in EXEC -> useZero=1, opAlu=0001, pc_redirect=1 in WB, reg_we=0; repeat with cond_in=0 -> pc_redirect=0.
REQ-028 LW with mem_ack after 4 MEM cycles -> mem_req high 4 cycles, mem_we=0, retire at accept+7, stall_count=3 when EXEC_SEQ_PERFCNT_EN.
REQ-029 ALUI MVHI (op1=1000, op2=1011) -> isMvhi=1, useZero=1, useImm=1, reg_we=1.
REQ-030 op1=1111 -> illegal pulses 1 cycle in DECODE, no retire, inst_ready=1 next cycle.
REQ-031 reset_n low for 1 cycle mid-MEM on SW -> mem_req, mem_we 0 immediately, IDLE after release, no retire.
